// File: rtl/axis_pkt_guard.sv
// Ingress packet-validity stage: checks beat count and mty per packet, forwards
// beats through one register stage, truncates oversize packets and flags bad ones.
module axis_pkt_guard #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MTY_WIDTH  = 8,
  parameter int unsigned MIN_BEATS  = 4,
  parameter int unsigned MAX_BEATS  = 16,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic [MTY_WIDTH-1:0]  s_axis_tuser_mty,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [MTY_WIDTH-1:0]  m_axis_tuser_mty,
  input  logic                  m_axis_tready,
  output logic                  drop_incmpt_pkt,
  output logic [CNT_WIDTH-1:0]  pkt_ok_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_drop_cnt
);

  localparam int unsigned N_W = $clog2(MAX_BEATS + 1);

  typedef enum logic {PASS = 1'b0, DISCARD = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [N_W-1:0]        n, n_nxt, beat_num;
  logic                  err, err_nxt;
  logic                  accept, mty_nz;
  logic                  tvalid_nxt, tlast_nxt, drop_nxt;
  logic [DATA_WIDTH-1:0] tdata_nxt;
  logic [MTY_WIDTH-1:0]  tmty_nxt;
  logic [CNT_WIDTH-1:0]  ok_cnt_nxt, drop_cnt_nxt;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Discard mode sinks beats without touching the output register, so it never stalls.
  assign s_axis_tready = ~areset & ((state == DISCARD) | ~m_axis_tvalid | m_axis_tready);
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign beat_num      = n + N_W'(1);
  assign mty_nz        = |s_axis_tuser_mty;

  // Next-state, beat tracking and output-register load.
  always_comb begin
    state_nxt    = state;
    n_nxt        = n;
    err_nxt      = err;
    tvalid_nxt   = m_axis_tvalid & ~m_axis_tready;
    tdata_nxt    = m_axis_tdata;
    tlast_nxt    = m_axis_tlast;
    tmty_nxt     = m_axis_tuser_mty;
    drop_nxt     = drop_incmpt_pkt;
    ok_cnt_nxt   = pkt_ok_cnt;
    drop_cnt_nxt = pkt_drop_cnt;
    case (state)
      PASS: begin
        if (accept) begin
          tvalid_nxt = 1'b1;
          tdata_nxt  = s_axis_tdata;
          tlast_nxt  = s_axis_tlast;
          tmty_nxt   = s_axis_tuser_mty;
          drop_nxt   = 1'b0;
          if (s_axis_tlast) begin
            drop_nxt = (beat_num < N_W'(MIN_BEATS)) | err;
            n_nxt    = '0;
            err_nxt  = 1'b0;
            if (drop_nxt) drop_cnt_nxt = sat_inc(pkt_drop_cnt);
            else          ok_cnt_nxt   = sat_inc(pkt_ok_cnt);
          end else if (beat_num == N_W'(MAX_BEATS)) begin
            // Oversize: close the packet here as a drop and sink the remainder.
            tlast_nxt    = 1'b1;
            tmty_nxt     = '0;
            drop_nxt     = 1'b1;
            n_nxt        = '0;
            err_nxt      = 1'b0;
            state_nxt    = DISCARD;
            drop_cnt_nxt = sat_inc(pkt_drop_cnt);
          end else begin
            n_nxt   = beat_num;
            err_nxt = err | mty_nz;
          end
        end
      end
      DISCARD: begin
        if (accept && s_axis_tlast) state_nxt = PASS;
      end
      default: state_nxt = PASS;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state            <= PASS;
      n                <= '0;
      err              <= 1'b0;
      m_axis_tvalid    <= 1'b0;
      m_axis_tdata     <= '0;
      m_axis_tlast     <= 1'b0;
      m_axis_tuser_mty <= '0;
      drop_incmpt_pkt  <= 1'b0;
      pkt_ok_cnt       <= '0;
      pkt_drop_cnt     <= '0;
    end else begin
      state            <= state_nxt;
      n                <= n_nxt;
      err              <= err_nxt;
      m_axis_tvalid    <= tvalid_nxt;
      m_axis_tdata     <= tdata_nxt;
      m_axis_tlast     <= tlast_nxt;
      m_axis_tuser_mty <= tmty_nxt;
      drop_incmpt_pkt  <= drop_nxt;
      pkt_ok_cnt       <= ok_cnt_nxt;
      pkt_drop_cnt     <= drop_cnt_nxt;
    end
  end

endmodule
